alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_pkg.sv | 14 +
 rtl/rr_arb2.sv | 14 +
 rtl/alu_sched.sv | 139 +++++++++++++
 tb/tb_alu_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared operand/opcode widths and FSM encoding for the ALU scheduler.
package alu_pkg;

  localparam int OPND_W = 2;
  localparam int OPC_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Stateless two-way round-robin grant; the caller owns the last-grant pointer.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  // last=1 means requester 1 was granted most recently, so requester 0 wins a tie.
  assign gnt0 = valid0 & (~valid1 | last);
  assign gnt1 = valid1 & (~valid0 | ~last);

endmodule

// File: rtl/alu_sched.sv
// Time-shares one external 2-bit ALU between two requesters with round-robin
// arbitration and a fixed response latency of ALU_LAT+2 edges after acceptance.
module alu_sched
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [OPND_W-1:0] req0_a,
  input  logic [OPND_W-1:0] req0_b,
  input  logic [OPND_W-1:0] req1_a,
  input  logic [OPND_W-1:0] req1_b,
  input  logic [OPC_W-1:0]  req0_p,
  input  logic [OPC_W-1:0]  req1_p,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [OPND_W-1:0] rsp_c,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [OPC_W-1:0]  alu_p,
  input  logic [OPND_W-1:0] alu_c,
  output logic              busy,
  output logic [7:0]        op_count
);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                win_q, win_d;
  logic [OPND_W-1:0]   aluA_q, aluA_d;
  logic [OPND_W-1:0]   aluB_q, aluB_d;
  logic [OPC_W-1:0]    aluP_q, aluP_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [OPND_W-1:0]   rspC_q, rspC_d;
  logic                rsp0_q, rsp0_d;
  logic                rsp1_q, rsp1_d;
  logic [7:0]          opCount_q, opCount_d;
  logic                gnt0, gnt1;

  rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .last   (last_q),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign req0_ready = ~rst & (state_q == IDLE) & gnt0;
  assign req1_ready = ~rst & (state_q == IDLE) & gnt1;

  // The response strobe and count update are registered out of RESP, which
  // places the strobe in the first IDLE cycle and gives the ALU_LAT+2 latency.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    aluA_d    = aluA_q;
    aluB_d    = aluB_q;
    aluP_d    = aluP_q;
    cnt_d     = cnt_q;
    rspC_d    = rspC_q;
    rsp0_d    = 1'b0;
    rsp1_d    = 1'b0;
    opCount_d = opCount_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d = EXEC;
          win_d   = req1_ready;
          last_d  = req1_ready;
          aluA_d  = req1_ready ? req1_a : req0_a;
          aluB_d  = req1_ready ? req1_b : req0_b;
          aluP_d  = req1_ready ? req1_p : req0_p;
        end
      end
      EXEC: begin
        cnt_d   = 3'(ALU_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          rspC_d  = alu_c;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        rsp0_d    = ~win_q;
        rsp1_d    = win_q;
        opCount_d = opCount_q + 8'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      aluA_q    <= '0;
      aluB_q    <= '0;
      aluP_q    <= '0;
      cnt_q     <= 3'd0;
      rspC_q    <= '0;
      rsp0_q    <= 1'b0;
      rsp1_q    <= 1'b0;
      opCount_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      aluA_q    <= aluA_d;
      aluB_q    <= aluB_d;
      aluP_q    <= aluP_d;
      cnt_q     <= cnt_d;
      rspC_q    <= rspC_d;
      rsp0_q    <= rsp0_d;
      rsp1_q    <= rsp1_d;
      opCount_q <= opCount_d;
    end
  end

  assign alu_a      = aluA_q;
  assign alu_b      = aluB_q;
  assign alu_p      = aluP_q;
  assign rsp_c      = rspC_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign op_count   = opCount_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: XOR ALU stubs at latency 1 (main DUT) and 3.
module tb_alu_sched;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_p, req1_p;
  logic       rsp0_valid, rsp1_valid;
  logic [1:0] rsp_c, alu_a, alu_b, alu_c;
  logic [2:0] alu_p;
  logic       busy;
  logic [7:0] op_count;

  logic       v3, ready30, ready31, rsp30, rsp31, busy3;
  logic [1:0] rspC3, aluA3, aluB3, aluC3, s1, s2;
  logic [2:0] aluP3;
  logic [7:0] opCount3;

  int checks;
  int failures;
  int busyViol;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] p;
    logic [1:0] c;
  } vec_t;

  vec_t vecs[8];

  alu_sched #(.ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_p(req0_p), .req1_p(req1_p),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_c(rsp_c),
    .alu_a(alu_a), .alu_b(alu_b), .alu_p(alu_p), .alu_c(alu_c),
    .busy(busy), .op_count(op_count)
  );

  alu_sched #(.ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(v3), .req1_valid(1'b0),
    .req0_ready(ready30), .req1_ready(ready31),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_p(req0_p), .req1_p(req1_p),
    .rsp0_valid(rsp30), .rsp1_valid(rsp31), .rsp_c(rspC3),
    .alu_a(aluA3), .alu_b(aluB3), .alu_p(aluP3), .alu_c(aluC3),
    .busy(busy3), .op_count(opCount3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // XOR ALU stubs: one register stage for the main DUT, three for the second.
  always @(posedge clk) begin
    alu_c <= alu_a ^ alu_b;
    s1    <= aluA3 ^ aluB3;
    s2    <= s1;
    aluC3 <= s2;
  end

  always @(negedge clk) begin
    if (busy && (req0_ready || req1_ready)) busyViol++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int expVal);
    checks++;
    if (act != expVal) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expVal);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one req0 operation and reports latency, the opcode on alu_p during
  // EXEC and the returned result; lat stays -1 if anything times out.
  task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b, input logic [2:0] p,
                               output int lat, output logic [2:0] pSeen, output logic [1:0] cSeen);
    int waitCnt;
    lat   = -1;
    pSeen = '0;
    cSeen = '0;
    req0_a = a; req0_b = b; req0_p = p; req0_valid = 1'b1;
    #1;
    waitCnt = 0;
    while (!req0_ready && waitCnt < 10) begin
      @(negedge clk); #1;
      waitCnt++;
    end
    if (!req0_ready) begin
      req0_valid = 1'b0;
      return;
    end
    @(posedge clk); @(negedge clk);
    pSeen = alu_p;
    req0_valid = 1'b0; req0_a = ~a; req0_b = ~b; req0_p = ~p;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); @(negedge clk);
      if (rsp0_valid) begin
        lat   = e;
        cSeen = rsp_c;
        break;
      end
    end
  endtask

  initial begin
    int lat, who, gotRsp, strobes;
    logic [2:0] pSeen;
    logic [1:0] cSeen;

    vecs[0] = '{a: 2'd0, b: 2'd0, p: 3'd0, c: 2'd0};
    vecs[1] = '{a: 2'd1, b: 2'd2, p: 3'd1, c: 2'd3};
    vecs[2] = '{a: 2'd3, b: 2'd3, p: 3'd2, c: 2'd0};
    vecs[3] = '{a: 2'd2, b: 2'd3, p: 3'd3, c: 2'd1};
    vecs[4] = '{a: 2'd3, b: 2'd1, p: 3'd4, c: 2'd2};
    vecs[5] = '{a: 2'd0, b: 2'd3, p: 3'd5, c: 2'd3};
    vecs[6] = '{a: 2'd1, b: 2'd1, p: 3'd6, c: 2'd0};
    vecs[7] = '{a: 2'd2, b: 2'd0, p: 3'd7, c: 2'd2};

    checks = 0; failures = 0; busyViol = 0;
    rst = 1'b1; v3 = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 2'd3; req0_b = 2'd3; req0_p = 3'd7;
    req1_a = 2'd3; req1_b = 2'd3; req1_p = 3'd7;

    repeat (2) @(negedge clk);
    checkOutput("reset req0_ready", int'(req0_ready), 0);
    checkOutput("reset req1_ready", int'(req1_ready), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset op_count", int'(op_count), 0);
    checkOutput("reset rsp_c", int'(rsp_c), 0);
    checkOutput("reset alu_a", int'(alu_a), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    // Single request on req0.
    req0_a = 2'b10; req0_b = 2'b01; req0_p = 3'b000; req0_valid = 1'b1;
    #1;
    checkOutput("single req0_ready", int'(req0_ready), 1);
    checkOutput("single req1_ready", int'(req1_ready), 0);
    @(posedge clk); @(negedge clk);
    checkOutput("single busy in EXEC", int'(busy), 1);
    checkOutput("single alu_a", int'(alu_a), 2);
    checkOutput("single alu_b", int'(alu_b), 1);
    req0_valid = 1'b0; req0_a = 2'b00; req0_b = 2'b00;
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); @(negedge clk);
      if (rsp0_valid) begin lat = e; break; end
    end
    checkOutput("single latency", lat, 3);
    checkOutput("single rsp_c", int'(rsp_c), 3);
    checkOutput("single op_count", int'(op_count), 1);
    checkOutput("single rsp1_valid", int'(rsp1_valid), 0);
    @(negedge clk);
    checkOutput("single strobe width", int'(rsp0_valid), 0);
    checkOutput("single rsp_c hold", int'(rsp_c), 3);

    // Opcode sweep from the vector table.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].p, lat, pSeen, cSeen);
      checkOutput($sformatf("sweep%0d latency", i), lat, 3);
      checkOutput($sformatf("sweep%0d alu_p", i), int'(pSeen), int'(vecs[i].p));
      checkOutput($sformatf("sweep%0d rsp_c", i), int'(cSeen), int'(vecs[i].c));
    end
    checkOutput("sweep op_count", int'(op_count), 9);

    // req1 arrives while req0 is in flight and must wait for IDLE.
    req0_a = 2'd1; req0_b = 2'd3; req0_p = 3'd2; req0_valid = 1'b1;
    #1;
    checkOutput("busyblk req0_ready", int'(req0_ready), 1);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    req1_a = 2'd2; req1_b = 2'd3; req1_p = 3'd4; req1_valid = 1'b1;
    #1;
    checkOutput("busyblk ready1 EXEC", int'(req1_ready), 0);
    @(posedge clk); @(negedge clk);
    checkOutput("busyblk ready1 WAIT", int'(req1_ready), 0);
    @(posedge clk); @(negedge clk);
    checkOutput("busyblk ready1 RESP", int'(req1_ready), 0);
    @(posedge clk); @(negedge clk);
    checkOutput("busyblk rsp0_valid", int'(rsp0_valid), 1);
    checkOutput("busyblk rsp_c req0", int'(rsp_c), 2);
    checkOutput("busyblk ready1 IDLE", int'(req1_ready), 1);
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    gotRsp = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); @(negedge clk);
      if (rsp1_valid) begin gotRsp = 1; break; end
    end
    checkOutput("busyblk rsp1_valid", gotRsp, 1);
    checkOutput("busyblk rsp_c req1", int'(rsp_c), 1);
    checkOutput("busyblk op_count", int'(op_count), 11);

    // Asynchronous reset while the operation sits in WAIT.
    req0_a = 2'd3; req0_b = 2'd1; req0_p = 3'd5; req0_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("rstwait busy before", int'(busy), 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstwait busy", int'(busy), 0);
    checkOutput("rstwait alu_a", int'(alu_a), 0);
    checkOutput("rstwait alu_p", int'(alu_p), 0);
    checkOutput("rstwait rsp_c", int'(rsp_c), 0);
    checkOutput("rstwait op_count", int'(op_count), 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) strobes++;
    end
    checkOutput("rstwait no strobe", strobes, 0);
    checkOutput("rstwait op_count after", int'(op_count), 0);

    // Repeated ties from a fresh pointer: grants must alternate 0,1,0,1.
    req0_a = 2'd1; req0_b = 2'd2; req0_p = 3'd0;
    req1_a = 2'd3; req1_b = 2'd1; req1_p = 3'd0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      who = -1;
      for (int w = 0; w < 10; w++) begin
        if (req0_ready) begin who = 0; break; end
        if (req1_ready) begin who = 1; break; end
        @(negedge clk);
      end
      checkOutput($sformatf("tie%0d winner", k), who, k % 2);
      if (who < 0) break;
      @(posedge clk); @(negedge clk);
      gotRsp = -1;
      cSeen = '0;
      for (int e = 1; e <= 20; e++) begin
        @(posedge clk); @(negedge clk);
        if (rsp0_valid) begin gotRsp = 0; cSeen = rsp_c; break; end
        if (rsp1_valid) begin gotRsp = 1; cSeen = rsp_c; break; end
      end
      checkOutput($sformatf("tie%0d rsp id", k), gotRsp, k % 2);
      checkOutput($sformatf("tie%0d rsp_c", k), int'(cSeen), (k % 2 == 1) ? 2 : 3);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkOutput("tie op_count", int'(op_count), 4);

    // op_count wraps after 256 completed operations.
    doReset();
    for (int n = 0; n < 255; n++) begin
      applyStimulus(n[1:0], n[3:2], n[2:0], lat, pSeen, cSeen);
    end
    checkOutput("wrap op_count 255", int'(op_count), 255);
    applyStimulus(2'd1, 2'd0, 3'd3, lat, pSeen, cSeen);
    checkOutput("wrap op_count 0", int'(op_count), 0);
    checkOutput("wrap last rsp_c", int'(cSeen), 1);

    // Latency with ALU_LAT=3 on the second instance.
    req0_a = 2'd2; req0_b = 2'd3; req0_p = 3'd6; v3 = 1'b1;
    #1;
    checkOutput("lat3 ready", int'(ready30), 1);
    @(posedge clk); @(negedge clk);
    checkOutput("lat3 busy", int'(busy3), 1);
    checkOutput("lat3 alu_p", int'(aluP3), 6);
    v3 = 1'b0;
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); @(negedge clk);
      if (rsp30) begin lat = e; break; end
    end
    checkOutput("lat3 latency", lat, 5);
    checkOutput("lat3 rsp_c", int'(rspC3), 1);
    checkOutput("lat3 rsp1 quiet", int'(rsp31), 0);
    checkOutput("lat3 op_count", int'(opCount3), 1);

    checkOutput("ready while busy", busyViol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
